// File: rtl/fb_pkg.sv
// Frame buffer write sequencer: shared state type, default geometry and sizing helper.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        PENDING = 2'd2
    } fb_state_e;

    localparam int unsigned DEF_WORDS_PER_LINE = 160;
    localparam int unsigned DEF_LINES          = 480;
    localparam int unsigned DEF_OFFS_W         = 17;

    // Smallest in-bank offset width able to address every word of a frame
    function automatic int unsigned min_offs_w(input int unsigned wpl, input int unsigned lines);
        return ((wpl * lines) > 1) ? $clog2(wpl * lines) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Pixel stream in and RAM write bus out of the frame buffer write sequencer.
interface frame_buffer_ctrl_if #(
    parameter int unsigned OFFS_W = 17
);
    logic              frame_start;
    logic              frame_end;
    logic              line_start;
    logic              pix_valid;
    logic [31:0]       pix_data;
    logic              wr_en;
    logic [OFFS_W:0]   wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output frame_start, frame_end, line_start, pix_valid, pix_data,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  frame_start, frame_end, line_start, pix_valid, pix_data,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_addr_gen.sv
// Line/word tracking and in-bank offset generation for the frame buffer writer.
// FB_TEST_PATTERN_EN adds the test-pattern word derived from the current position.
module fb_addr_gen #(
    parameter int unsigned WORDS_PER_LINE = 160,
    parameter int unsigned LINES          = 480,
    parameter int unsigned OFFS_W         = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              active,
    input  logic              line_start,
    input  logic              pix_valid,
    output logic [OFFS_W-1:0] offset_c,
    output logic              wr_ok_c,
    output logic              ovf_c,
`ifdef FB_TEST_PATTERN_EN
    output logic [31:0]       tp_data_c,
`endif
    output logic              complete_c
);

    localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE + 1);

    logic              has_line;
    logic              line_ovf;
    logic [LINE_W-1:0] line_idx;
    logic [WORD_W-1:0] word_idx;
    logic [OFFS_W-1:0] line_base;

    logic              last_line;
    logic              new_line;
    logic              e_has;
    logic              e_line_ovf;
    logic [LINE_W-1:0] e_line;
    logic [WORD_W-1:0] e_word;
    logic [WORD_W-1:0] n_word;
    logic [OFFS_W-1:0] e_base;
    logic              word_ok;

    // Effective position for this cycle, folding in a same-cycle line_start
    always_comb begin
        last_line  = has_line && (line_idx == LINE_W'(LINES - 1));
        new_line   = active && line_start && !line_ovf && !last_line;
        e_line_ovf = line_ovf || (active && line_start && last_line);
        e_has      = has_line || new_line;
        e_line     = line_idx;
        e_base     = line_base;
        e_word     = word_idx;
        if (new_line) begin
            e_line = has_line ? (line_idx + LINE_W'(1)) : '0;
            e_base = has_line ? (line_base + OFFS_W'(WORDS_PER_LINE)) : '0;
            e_word = '0;
        end
        word_ok    = (e_word < WORD_W'(WORDS_PER_LINE));
        wr_ok_c    = active && pix_valid && e_has && !e_line_ovf && word_ok;
        ovf_c      = (active && line_start && (line_ovf || last_line)) ||
                     (active && pix_valid && e_has && (e_line_ovf || !word_ok));
        n_word     = wr_ok_c ? (e_word + WORD_W'(1)) : e_word;
        complete_c = e_has && (e_line == LINE_W'(LINES - 1)) &&
                     (n_word == WORD_W'(WORDS_PER_LINE));
        offset_c   = e_base + OFFS_W'(e_word);
    end

`ifdef FB_TEST_PATTERN_EN
    // Byte i of the pattern word is word*4 + i + line, modulo 256
    always_comb begin
        tp_data_c = '0;
        for (int i = 0; i < 4; i++) begin
            tp_data_c[i*8 +: 8] = 8'({e_word, 2'b00}) + 8'(i) + 8'(e_line);
        end
    end
`endif

    // Position registers; overflow lines leave the position untouched
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            has_line  <= 1'b0;
            line_ovf  <= 1'b0;
            line_idx  <= '0;
            word_idx  <= '0;
            line_base <= '0;
        end else begin
            has_line  <= e_has;
            line_ovf  <= e_line_ovf;
            line_idx  <= e_line;
            word_idx  <= n_word;
            line_base <= e_base;
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Camera frame buffer write sequencer with ping-pong banks swapped on display vsync.
// FB_TEST_PATTERN_EN adds tp_sel, which replaces camera data with a position pattern.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned OFFS_W         = DEF_OFFS_W
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               rd_vsync,
`ifdef FB_TEST_PATTERN_EN
    input  logic               tp_sel,
`endif
    frame_buffer_ctrl_if.slave bus,
    output logic               rd_bank,
    output logic [15:0]        frame_count,
    output logic               err_overflow,
    output logic               err_short,
    output logic               busy
);

    if (OFFS_W < min_offs_w(WORDS_PER_LINE, LINES)) begin : g_offs_w_check
        $error("OFFS_W too small for frame geometry");
    end

    fb_state_e         state;
    logic              wr_bank;
    logic              ovf_seen;
    logic              start_c;
    logic              active_c;
    logic [OFFS_W-1:0] offset_c;
    logic              wr_ok_c;
    logic              ovf_c;
    logic              complete_c;
    logic [31:0]       wr_data_c;

    // A frame is accepted from IDLE, or from PENDING when vsync swaps in the same cycle
    assign start_c  = bus.frame_start && enable &&
                      ((state == IDLE) || ((state == PENDING) && rd_vsync));
    assign active_c = (state == WRITE);

`ifdef FB_TEST_PATTERN_EN
    logic [31:0] tp_data_c;
    assign wr_data_c = tp_sel ? tp_data_c : bus.pix_data;
`else
    assign wr_data_c = bus.pix_data;
`endif

    fb_addr_gen #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINES          (LINES),
        .OFFS_W         (OFFS_W)
    ) u_addr_gen (
        .clk        (sys_clk),
        .reset      (reset),
        .clear      (start_c),
        .active     (active_c),
        .line_start (bus.line_start),
        .pix_valid  (bus.pix_valid),
        .offset_c   (offset_c),
        .wr_ok_c    (wr_ok_c),
        .ovf_c      (ovf_c),
`ifdef FB_TEST_PATTERN_EN
        .tp_data_c  (tp_data_c),
`endif
        .complete_c (complete_c)
    );

    // Frame FSM, bank swap, error pulses and registered RAM write port
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b1;
            frame_count  <= '0;
            ovf_seen     <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
        end else begin
            bus.wr_en    <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state    <= WRITE;
                        busy     <= 1'b1;
                        ovf_seen <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_ok_c) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= {wr_bank, offset_c};
                        bus.wr_data <= wr_data_c;
                    end
                    if (ovf_c && !ovf_seen) begin
                        err_overflow <= 1'b1;
                        ovf_seen     <= 1'b1;
                    end
                    if (bus.frame_end) begin
                        if (complete_c) begin
                            state <= PENDING;
                        end else begin
                            err_short <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                PENDING: begin
                    if (rd_vsync) begin
                        rd_bank     <= wr_bank;
                        wr_bank     <= ~wr_bank;
                        frame_count <= frame_count + 16'd1;
                        if (start_c) begin
                            state    <= WRITE;
                            ovf_seen <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl with a 4-word x 3-line geometry.
// With FB_TEST_PATTERN_EN defined the test-pattern scenario is also run.
module tb_frame_buffer_ctrl;

    localparam int unsigned WPL = 4;
    localparam int unsigned NL  = 3;
    localparam int unsigned OW  = 4;

    typedef struct {
        logic [OW:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rd_vsync;
    logic        rd_bank;
    logic [15:0] frame_count;
    logic        err_overflow;
    logic        err_short;
    logic        busy;
`ifdef FB_TEST_PATTERN_EN
    logic        tp_sel = 1'b0;
`endif

    frame_buffer_ctrl_if #(.OFFS_W(OW)) bus ();

    frame_buffer_ctrl #(
        .WORDS_PER_LINE (WPL),
        .LINES          (NL),
        .OFFS_W         (OW)
    ) dut (
        .sys_clk      (clk),
        .reset        (reset),
        .enable       (enable),
        .rd_vsync     (rd_vsync),
`ifdef FB_TEST_PATTERN_EN
        .tp_sel       (tp_sel),
`endif
        .bus          (bus),
        .rd_bank      (rd_bank),
        .frame_count  (frame_count),
        .err_overflow (err_overflow),
        .err_short    (err_short),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;
    int          obs_n = 0;
    int          obs_rd = 0;
    int          ovf_cnt = 0;
    int          short_cnt = 0;
    bit          tp_on = 1'b0;
    logic [OW:0] obs_addr [0:1023];
    logic [31:0] obs_data [0:1023];
    int          obs_cyc  [0:1023];
    exp_t        exp_q[$];

    // Record every RAM write and count error-pulse cycles
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1 && obs_n < 1024) begin
            obs_addr[obs_n] = bus.wr_addr;
            obs_data[obs_n] = bus.wr_data;
            obs_cyc[obs_n]  = ncyc;
            obs_n++;
        end
        if (err_overflow === 1'b1) ovf_cnt++;
        if (err_short === 1'b1) short_cnt++;
        ncyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.line_start  = 1'b0;
        bus.pix_valid   = 1'b0;
        rd_vsync        = 1'b0;
    endtask

    // Drive nlines lines (long_line gets 5 words) and queue the writes the geometry allows
    task automatic send_lines(input int nlines, input int long_line, input bit bank,
                              input bit exp_on, input bit fe_merge, input int base,
                              input bit do_end);
        int   k = 0;
        int   nw;
        exp_t e;
        for (int l = 0; l < nlines; l++) begin
            nw = (l == long_line) ? WPL + 1 : WPL;
            for (int w = 0; w < nw; w++) begin
                bus.line_start = (w == 0);
                bus.pix_valid  = 1'b1;
                bus.pix_data   = 32'(base + k);
                bus.frame_end  = do_end && fe_merge && (l == nlines - 1) && (w == nw - 1);
                if (exp_on && l < int'(NL) && w < int'(WPL)) begin
                    e.a = {bank, 4'(l * WPL + w)};
                    if (tp_on)
                        e.d = {8'(w*4 + 3 + l), 8'(w*4 + 2 + l), 8'(w*4 + 1 + l), 8'(w*4 + l)};
                    else
                        e.d = 32'(base + k);
                    e.c = ncyc + 1;
                    exp_q.push_back(e);
                end
                k++;
                tick();
            end
            if (!(fe_merge && l == nlines - 1)) tick();
        end
        if (do_end && !fe_merge) begin
            bus.frame_end = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        rd_vsync = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.line_start  = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = '0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
        total++; if (bus.wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", bus.wr_addr); end
        total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL reset_rd_bank got=%b exp=1", rd_bank); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err_overflow !== 1'b0 || err_short !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", err_overflow, err_short); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        exp_t e;
        int   sc = short_cnt;
        enable = 1'b1;
        bus.frame_start = 1'b1; tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy_write got=%b exp=1", busy); end
        send_lines(3, -1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        total++; if (busy !== 1'b1 || rd_bank !== 1'b1) begin bad++; $display("FAIL full_pending got busy=%b rd_bank=%b exp 1 1", busy, rd_bank); end
        rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b0 || frame_count !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL full_swap1 got rd_bank=%b fc=%0d busy=%b exp 0 1 0", rd_bank, frame_count, busy); end
        bus.frame_start = 1'b1; tick();
        send_lines(3, -1, 1'b1, 1'b1, 1'b1, 100, 1'b1);
        rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b1 || frame_count !== 16'd2) begin bad++; $display("FAIL full_swap2 got rd_bank=%b fc=%0d exp 1 2", rd_bank, frame_count); end
        repeat (3) tick();
        total++; if (short_cnt != sc) begin bad++; $display("FAIL full_err_short got=%0d exp=0", short_cnt - sc); end
        while (exp_q.size() != 0 || obs_rd != obs_n) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL full_extra_write got addr=%h exp none", obs_addr[obs_rd]); obs_rd++; end
            else if (obs_rd == obs_n) begin e = exp_q.pop_front(); bad++; $display("FAIL full_missing_write got none exp addr=%h", e.a); end
            else begin
                e = exp_q.pop_front();
                if (obs_addr[obs_rd] !== e.a || obs_data[obs_rd] !== e.d || obs_cyc[obs_rd] != e.c) begin
                    bad++; $display("FAIL full_write got %h/%h@%0d exp %h/%h@%0d", obs_addr[obs_rd], obs_data[obs_rd], obs_cyc[obs_rd], e.a, e.d, e.c);
                end
                obs_rd++;
            end
        end
    endtask

    task automatic test_short_frame();
        exp_t e;
        int   sc = short_cnt;
        bus.frame_start = 1'b1; tick();
        send_lines(2, -1, 1'b0, 1'b1, 1'b0, 200, 1'b1);
        repeat (2) tick();
        total++; if (short_cnt - sc != 1) begin bad++; $display("FAIL short_pulse got=%0d exp=1", short_cnt - sc); end
        total++; if (rd_bank !== 1'b1 || frame_count !== 16'd2 || busy !== 1'b0) begin bad++; $display("FAIL short_noswap got rd_bank=%b fc=%0d busy=%b exp 1 2 0", rd_bank, frame_count, busy); end
        rd_vsync = 1'b1; tick();
        total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL short_vsync_idle got fc=%0d exp=2", frame_count); end
        bus.frame_start = 1'b1; tick();
        send_lines(3, -1, 1'b0, 1'b1, 1'b0, 300, 1'b1);
        rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b0 || frame_count !== 16'd3) begin bad++; $display("FAIL short_swap got rd_bank=%b fc=%0d exp 0 3", rd_bank, frame_count); end
        repeat (3) tick();
        while (exp_q.size() != 0 || obs_rd != obs_n) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL short_extra_write got addr=%h exp none", obs_addr[obs_rd]); obs_rd++; end
            else if (obs_rd == obs_n) begin e = exp_q.pop_front(); bad++; $display("FAIL short_missing_write got none exp addr=%h", e.a); end
            else begin
                e = exp_q.pop_front();
                if (obs_addr[obs_rd] !== e.a || obs_data[obs_rd] !== e.d || obs_cyc[obs_rd] != e.c) begin
                    bad++; $display("FAIL short_write got %h/%h@%0d exp %h/%h@%0d", obs_addr[obs_rd], obs_data[obs_rd], obs_cyc[obs_rd], e.a, e.d, e.c);
                end
                obs_rd++;
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int   oc = ovf_cnt;
        int   sc = short_cnt;
        bus.frame_start = 1'b1; tick();
        send_lines(4, 1, 1'b1, 1'b1, 1'b0, 400, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_pending got busy=%b exp=1", busy); end
        rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b1 || frame_count !== 16'd4) begin bad++; $display("FAIL ovf_swap got rd_bank=%b fc=%0d exp 1 4", rd_bank, frame_count); end
        repeat (3) tick();
        total++; if (ovf_cnt - oc != 1) begin bad++; $display("FAIL ovf_pulse got=%0d exp=1", ovf_cnt - oc); end
        total++; if (short_cnt != sc) begin bad++; $display("FAIL ovf_short got=%0d exp=0", short_cnt - sc); end
        while (exp_q.size() != 0 || obs_rd != obs_n) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL ovf_extra_write got addr=%h exp none", obs_addr[obs_rd]); obs_rd++; end
            else if (obs_rd == obs_n) begin e = exp_q.pop_front(); bad++; $display("FAIL ovf_missing_write got none exp addr=%h", e.a); end
            else begin
                e = exp_q.pop_front();
                if (obs_addr[obs_rd] !== e.a || obs_data[obs_rd] !== e.d || obs_cyc[obs_rd] != e.c) begin
                    bad++; $display("FAIL ovf_write got %h/%h@%0d exp %h/%h@%0d", obs_addr[obs_rd], obs_data[obs_rd], obs_cyc[obs_rd], e.a, e.d, e.c);
                end
                obs_rd++;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.frame_start = 1'b1; tick();
        send_lines(3, -1, 1'b0, 1'b1, 1'b0, 500, 1'b1);
        bus.frame_start = 1'b1; rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b0 || frame_count !== 16'd5 || busy !== 1'b1) begin bad++; $display("FAIL b2b_swap got rd_bank=%b fc=%0d busy=%b exp 0 5 1", rd_bank, frame_count, busy); end
        send_lines(3, -1, 1'b1, 1'b1, 1'b0, 600, 1'b1);
        bus.frame_start = 1'b1; tick();
        send_lines(2, -1, 1'b0, 1'b0, 1'b0, 700, 1'b0);
        rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b1 || frame_count !== 16'd6 || busy !== 1'b0) begin bad++; $display("FAIL drop_swap got rd_bank=%b fc=%0d busy=%b exp 1 6 0", rd_bank, frame_count, busy); end
        send_lines(1, -1, 1'b0, 1'b0, 1'b0, 800, 1'b1);
        repeat (3) tick();
        while (exp_q.size() != 0 || obs_rd != obs_n) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra_write got addr=%h exp none", obs_addr[obs_rd]); obs_rd++; end
            else if (obs_rd == obs_n) begin e = exp_q.pop_front(); bad++; $display("FAIL b2b_missing_write got none exp addr=%h", e.a); end
            else begin
                e = exp_q.pop_front();
                if (obs_addr[obs_rd] !== e.a || obs_data[obs_rd] !== e.d || obs_cyc[obs_rd] != e.c) begin
                    bad++; $display("FAIL b2b_write got %h/%h@%0d exp %h/%h@%0d", obs_addr[obs_rd], obs_data[obs_rd], obs_cyc[obs_rd], e.a, e.d, e.c);
                end
                obs_rd++;
            end
        end
    endtask

    task automatic test_enable();
        exp_t e;
        enable = 1'b0;
        bus.frame_start = 1'b1; tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_off_busy got=%b exp=0", busy); end
        send_lines(3, -1, 1'b0, 1'b0, 1'b0, 900, 1'b1);
        enable = 1'b1;
        bus.frame_start = 1'b1; tick();
        enable = 1'b0;
        send_lines(3, -1, 1'b0, 1'b1, 1'b0, 1000, 1'b1);
        rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b0 || frame_count !== 16'd7) begin bad++; $display("FAIL en_swap got rd_bank=%b fc=%0d exp 0 7", rd_bank, frame_count); end
        enable = 1'b1;
        repeat (3) tick();
        while (exp_q.size() != 0 || obs_rd != obs_n) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL en_extra_write got addr=%h exp none", obs_addr[obs_rd]); obs_rd++; end
            else if (obs_rd == obs_n) begin e = exp_q.pop_front(); bad++; $display("FAIL en_missing_write got none exp addr=%h", e.a); end
            else begin
                e = exp_q.pop_front();
                if (obs_addr[obs_rd] !== e.a || obs_data[obs_rd] !== e.d || obs_cyc[obs_rd] != e.c) begin
                    bad++; $display("FAIL en_write got %h/%h@%0d exp %h/%h@%0d", obs_addr[obs_rd], obs_data[obs_rd], obs_cyc[obs_rd], e.a, e.d, e.c);
                end
                obs_rd++;
            end
        end
    endtask

`ifdef FB_TEST_PATTERN_EN
    task automatic test_pattern();
        exp_t e;
        tp_sel = 1'b1;
        tp_on  = 1'b1;
        bus.frame_start = 1'b1; tick();
        send_lines(3, -1, 1'b1, 1'b1, 1'b0, 32'h5A5A0000, 1'b1);
        rd_vsync = 1'b1; tick();
        total++; if (rd_bank !== 1'b1 || frame_count !== 16'd8) begin bad++; $display("FAIL tp_swap got rd_bank=%b fc=%0d exp 1 8", rd_bank, frame_count); end
        tp_sel = 1'b0;
        tp_on  = 1'b0;
        repeat (3) tick();
        while (exp_q.size() != 0 || obs_rd != obs_n) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL tp_extra_write got addr=%h exp none", obs_addr[obs_rd]); obs_rd++; end
            else if (obs_rd == obs_n) begin e = exp_q.pop_front(); bad++; $display("FAIL tp_missing_write got none exp addr=%h", e.a); end
            else begin
                e = exp_q.pop_front();
                if (obs_addr[obs_rd] !== e.a || obs_data[obs_rd] !== e.d || obs_cyc[obs_rd] != e.c) begin
                    bad++; $display("FAIL tp_write got %h/%h@%0d exp %h/%h@%0d", obs_addr[obs_rd], obs_data[obs_rd], obs_cyc[obs_rd], e.a, e.d, e.c);
                end
                obs_rd++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_overflow();
        test_back_to_back();
        test_enable();
`ifdef FB_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
